// File: rtl/approx_mul_err_sweep.sv
// Exhaustive error sweep around an approximate WxW multiplier.
// Drives every operand pair and accumulates count/abs/squared/max error against the exact product.
module approx_mul_err_sweep #(
    parameter int W     = 8,
    parameter int SSE_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pause,
    output logic [W-1:0]         op_a,
    output logic [W-1:0]         op_b,
    input  logic [2*W-1:0]       approx_prod,
    output logic                 busy,
    output logic                 done,
    output logic [2*W:0]         err_cnt,
    output logic [4*W-1:0]       sum_abs,
    output logic [SSE_W-1:0]     sum_sq,
    output logic [2*W-1:0]       max_abs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2*W-1:0] CNT_LAST = '1;

    state_t                state_q, state_d;
    logic [2*W-1:0]        cnt_q, cnt_d;
    logic                  s1_vld_q, s1_vld_d;
    logic signed [2*W:0]   s1_err_q, s1_err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2*W:0]          err_cnt_q, err_cnt_d;
    logic [4*W-1:0]        sum_abs_q, sum_abs_d;
    logic [SSE_W-1:0]      sum_sq_q, sum_sq_d;
    logic [2*W-1:0]        max_abs_q, max_abs_d;

    logic [2*W-1:0]        exact;
    logic signed [2*W:0]   err_raw;
    logic [2*W-1:0]        abs_e;
    logic [4*W-1:0]        sq_e;

    assign exact   = {{W{1'b0}}, cnt_q[W-1:0]} * {{W{1'b0}}, cnt_q[2*W-1:W]};
    assign err_raw = signed'({1'b0, approx_prod}) - signed'({1'b0, exact});
    // |e| always fits 2W bits: the most negative error is -(2^W-1)^2
    assign abs_e   = s1_err_q[2*W] ? (2*W)'(-s1_err_q) : s1_err_q[2*W-1:0];
    assign sq_e    = {{2*W{1'b0}}, abs_e} * {{2*W{1'b0}}, abs_e};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s1_vld_d  = 1'b0;
        s1_err_d  = s1_err_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_cnt_d = err_cnt_q;
        sum_abs_d = sum_abs_q;
        sum_sq_d  = sum_sq_q;
        max_abs_d = max_abs_q;

        if (s1_vld_q) begin
            err_cnt_d = err_cnt_q + {{2*W{1'b0}}, (s1_err_q != '0)};
            sum_abs_d = sum_abs_q + {{2*W{1'b0}}, abs_e};
            sum_sq_d  = sum_sq_q + SSE_W'(sq_e);
            if (abs_e > max_abs_q) begin
                max_abs_d = abs_e;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_SWEEP;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_cnt_d = '0;
                    sum_abs_d = '0;
                    sum_sq_d  = '0;
                    max_abs_d = '0;
                end
            end
            S_SWEEP: begin
                s1_vld_d = !pause;
                s1_err_d = err_raw;
                if (!pause) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_err_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_cnt_q <= '0;
            sum_abs_q <= '0;
            sum_sq_q  <= '0;
            max_abs_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_err_q  <= s1_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_cnt_q <= err_cnt_d;
            sum_abs_q <= sum_abs_d;
            sum_sq_q  <= sum_sq_d;
            max_abs_q <= max_abs_d;
        end
    end

    assign op_a    = cnt_q[W-1:0];
    assign op_b    = cnt_q[2*W-1:W];
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_cnt_q;
    assign sum_abs = sum_abs_q;
    assign sum_sq  = sum_sq_q;
    assign max_abs = max_abs_q;

endmodule
